// File: rtl/elevator_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// elevator_pkg: FSM state type and floor-mask helpers shared by the elevator controller.
// Revision 1.0
package elevator_pkg;

    // The mask helpers support NUM_FLOORS up to this bound; callers truncate to their width.
    localparam int MAX_FLOORS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_e;

    function automatic logic [MAX_FLOORS-1:0] ahead_mask(input int flr, input logic dir_up);
        logic [MAX_FLOORS-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_FLOORS; k++) begin
            m[k] = dir_up ? (k > flr) : (k < flr);
        end
        return m;
    endfunction

    function automatic logic [MAX_FLOORS-1:0] onehot(input int idx);
        return MAX_FLOORS'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// elevator_tick_gen: free-running prescaler; tick is high while the count sits at TICK_CYCLES-1.
// Revision 1.0
module elevator_tick_gen #(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Holding parks the count at 0 so a release always waits a full period.
    always_comb begin
        cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
        if (hold) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !hold && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/elevator_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// elevator_scan_ctrl: N-floor SCAN elevator controller with latched calls and timed door dwell.
// Optional ELEVATOR_ESTOP_EN adds estop_i, which freezes motion and dwell while held. Revision 1.0
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 4,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int DOOR_TICKS  = 3,
    localparam int FW = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req_i,
`ifdef ELEVATOR_ESTOP_EN
    input  logic                  estop_i,
`endif
    output logic [FW-1:0]         floor_idx_o,
    output logic [NUM_FLOORS-1:0] floor_oh_o,
    output logic                  dir_up_o,
    output logic                  moving_o,
    output logic                  door_open_o,
    output logic [NUM_FLOORS-1:0] pending_o
);

    localparam int DW = $clog2(DOOR_TICKS + 1);

    logic w_tick;
    logic w_hold;

`ifdef ELEVATOR_ESTOP_EN
    assign w_hold = estop_i;
`else
    assign w_hold = 1'b0;
`endif

    elevator_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .hold (w_hold),
        .tick (w_tick)
    );

    state_e                state_q, state_d;
    logic [FW-1:0]         floor_q, floor_d;
    logic [NUM_FLOORS-1:0] floor_oh_q, floor_oh_d;
    logic                  dir_up_q, dir_up_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [DW-1:0]         dwell_q, dwell_d;
    logic                  moving_q, door_q;

    logic [NUM_FLOORS-1:0] w_pend_all;
    logic [NUM_FLOORS-1:0] w_ahead_fwd;
    logic [NUM_FLOORS-1:0] w_ahead_rev;
    logic [FW-1:0]         w_floor_step;
    logic [NUM_FLOORS-1:0] w_oh_step;
    logic [NUM_FLOORS-1:0] w_ahead_step;
    logic                  w_at_end;

    assign w_pend_all   = pending_q | req_i;
    assign w_ahead_fwd  = NUM_FLOORS'(ahead_mask(int'(floor_q), dir_up_q));
    assign w_ahead_rev  = NUM_FLOORS'(ahead_mask(int'(floor_q), !dir_up_q));
    assign w_floor_step = dir_up_q ? floor_q + FW'(1) : floor_q - FW'(1);
    assign w_oh_step    = NUM_FLOORS'(onehot(int'(w_floor_step)));
    assign w_ahead_step = NUM_FLOORS'(ahead_mask(int'(w_floor_step), dir_up_q));
    assign w_at_end     = dir_up_q ? (floor_q == FW'(NUM_FLOORS - 1)) : (floor_q == '0);

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        floor_oh_d = floor_oh_q;
        dir_up_d   = dir_up_q;
        pending_d  = w_pend_all;
        dwell_d    = dwell_q;
        if (!w_hold) begin
            case (state_q)
                IDLE: begin
                    if (w_pend_all[floor_q]) begin
                        state_d   = DOOR;
                        dwell_d   = DW'(DOOR_TICKS);
                        pending_d = w_pend_all & ~floor_oh_q;
                    end else if (|(w_pend_all & w_ahead_fwd)) begin
                        state_d = MOVE;
                    end else if (|(w_pend_all & w_ahead_rev)) begin
                        state_d  = MOVE;
                        dir_up_d = !dir_up_q;
                    end
                end
                MOVE: begin
                    if (w_tick) begin
                        // Never step past either end of the shaft.
                        if (w_at_end) begin
                            state_d = IDLE;
                        end else begin
                            floor_d    = w_floor_step;
                            floor_oh_d = w_oh_step;
                            if (w_pend_all[w_floor_step]) begin
                                state_d   = DOOR;
                                dwell_d   = DW'(DOOR_TICKS);
                                pending_d = w_pend_all & ~w_oh_step;
                            end else if (!(|(w_pend_all & w_ahead_step))) begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                DOOR: begin
                    pending_d = w_pend_all & ~floor_oh_q;
                    if (req_i[floor_q]) begin
                        dwell_d = DW'(DOOR_TICKS);
                    end else if (w_tick) begin
                        if (dwell_q <= DW'(1)) begin
                            state_d = IDLE;
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q - DW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            floor_q    <= '0;
            floor_oh_q <= NUM_FLOORS'(1);
            dir_up_q   <= 1'b1;
            pending_q  <= '0;
            dwell_q    <= '0;
            moving_q   <= 1'b0;
            door_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            floor_oh_q <= floor_oh_d;
            dir_up_q   <= dir_up_d;
            pending_q  <= pending_d;
            dwell_q    <= dwell_d;
            moving_q   <= (state_d == MOVE);
            door_q     <= (state_d == DOOR);
        end
    end

    assign floor_idx_o = floor_q;
    assign floor_oh_o  = floor_oh_q;
    assign dir_up_o    = dir_up_q;
    assign moving_o    = moving_q;
    assign door_open_o = door_q;
    assign pending_o   = pending_q;

endmodule
`default_nettype wire
